mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter sitting directly downstream of the CPU data-memory port inside top. The address decoder steers store/load accesses in its window here instead of to the 256-word memory. CPU stores push bytes into a small TX FIFO, and a serializer shifts them out on a single line. CPU loads return status so firmware can poll for space or idle.

---
 rtl/mmio_uart_tx.sv | 162 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO UART transmitter, TX FIFO plus 8N1 serializer.
// Define UART_TX_PARITY_EN to add an even parity bit before STOP.
module mmio_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic          tx_d;
  logic          tick;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, empty;
  logic          push, pop, drop, clr;
  logic          ovf;
  logic          feat;
  logic [31:0]   status;
  logic          unused;

  assign full  = count == DEPTH;
  assign empty = count == '0;
  assign push  = we && !addr[2] && !full;
  assign drop  = we && !addr[2] && full;
  assign clr   = we && addr[2] && wdata[3];
  assign pop   = (state == IDLE) && !empty;
  assign tick  = cnt == CMAX;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default:      count <= count;
      endcase
      // a fresh drop beats a same-cycle clear
      if (drop)     ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      par   <= par_n;
      tx    <= tx_d;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    par_n   = par;
    if (state != IDLE) cnt_n = tick ? '0 : cnt + 1'b1;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_n = START;
          cnt_n   = '0;
          shift_n = mem[rptr];
          par_n   = ^mem[rptr];
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_n = shift >> 1;
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
      PARITY: if (tick) state_n = STOP;
      STOP:   if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // tx is registered from next state so START goes low right after pop
  always_comb begin
    tx_d = 1'b1;
    unique case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_n[0];
      PARITY:  tx_d = par_n;
      default: tx_d = 1'b1;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  assign feat = 1'b1;
`else
  assign feat = 1'b0;
`endif

  assign tx_busy = (state != IDLE) || !empty;
  assign status  = {27'd0, feat, ovf, empty, full, tx_busy};
  assign rdata   = (re && addr[2]) ? status : 32'd0;
  assign unused  = ^{wdata[31:8], addr[1:0]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench, decodes tx frames with a line monitor.
// Parity checks enabled when UART_TX_PARITY_EN is defined.
module tb_mmio_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11 * CPB;
  localparam logic [31:0] FEAT = 32'h10;
`else
  localparam int FL = 10 * CPB;
  localparam logic [31:0] FEAT = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        tx;
  logic        tx_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int         t_q[$];
  logic       ok_q[$];
  logic       par_q[$];

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .wdata(wdata),
    .we(we),
    .re(re),
    .rdata(rdata),
    .tx(tx),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    we = 1'b1;
    addr = a;
    wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp,
                    input string tag);
    re = 1'b1;
    addr = a;
    #1 check(tag, rdata, exp);
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget,
                         input string tag);
    for (int i = 0; i < budget && rx_q.size() < n; i++)
      @(negedge clk);
    check(tag, rx_q.size(), n);
  endtask

  task automatic flush();
    rx_q.delete();
    t_q.delete();
    ok_q.delete();
    par_q.delete();
  endtask

  // line monitor: samples mid-bit, cycle 0 is the first low cycle
  initial begin
    logic [7:0] b;
    logic ok, p;
    int t;
    forever begin
      @(negedge clk);
      if (reset && tx === 1'b0) begin
        t = cyc;
        ok = 1'b1;
        repeat (CPB - 1) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        repeat (CPB / 2 + 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = tx;
          if (i < 7) repeat (CPB) @(negedge clk);
        end
        p = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        p = tx;
`endif
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
        rx_q.push_back(b);
        t_q.push_back(t);
        ok_q.push_back(ok);
        par_q.push_back(p);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp6 [6];
    int t0;
    exp6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_tx", tx, 1);
    rd(3'h4, 32'h4 | FEAT, "status_idle");
    rd(3'h0, 32'h0, "txdata_read");
    addr = 3'h4;
    #1 check("no_re", rdata, 0);

    // single frame 0x55
    wr(3'h0, 32'hFFFF_FF55);
    wait_rx(1, FL + 20, "rx1_count");
    if (rx_q.size() >= 1) begin
      check("rx1_byte", rx_q[0], 8'h55);
      check("rx1_frame", ok_q[0], 1);
      t0 = t_q[0];
      while (cyc - t0 < FL - 1) @(negedge clk);
      check("rx1_busy_last", tx_busy, 1);
      @(negedge clk);
      check("rx1_busy_end", tx_busy, 0);
      check("rx1_tx_end", tx, 1);
    end
    flush();

    // back to back
    wr(3'h0, 32'hA3);
    wr(3'h0, 32'h0F);
    wait_rx(2, 2 * FL + 20, "rx2_count");
    if (rx_q.size() >= 2) begin
      check("rx2_b0", rx_q[0], 8'hA3);
      check("rx2_b1", rx_q[1], 8'h0F);
      check("rx2_gap", t_q[1] - t_q[0], FL + 1);
      check("rx2_ok", {ok_q[0], ok_q[1]}, 2'b11);
    end
    repeat (5) @(negedge clk);
    flush();

    // overflow
    for (int i = 0; i < 6; i++) wr(3'h0, {24'd0, exp6[i]});
    rd(3'h4, 32'hB | FEAT, "st_ovf");
    wr(3'h4, 32'hFFFF_FFF7);
    rd(3'h4, 32'hB | FEAT, "st_noclr");
    wr(3'h4, 32'h8);
    rd(3'h4, 32'h3 | FEAT, "st_clr");
    wait_rx(5, 5 * (FL + 1) + 20, "rx5_count");
    repeat (FL) @(negedge clk);
    check("rx5_total", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      check($sformatf("rx5_b%0d", i), rx_q[i], exp6[i]);
      check($sformatf("rx5_ok%0d", i), ok_q[i], 1);
    end
    rd(3'h4, 32'h4 | FEAT, "st_drained");
    flush();

    // reset in the middle of data bit 3
    wr(3'h0, 32'h00);
    repeat (19) @(negedge clk);
    check("pre_rst_tx", tx, 0);
    #2 reset = 1'b0;
    #1 check("rst_async_tx", tx, 1);
    check("rst_async_busy", tx_busy, 0);
    @(negedge clk);
    reset = 1'b1;
    rd(3'h4, 32'h4 | FEAT, "st_after_rst");
    repeat (FL + 10) @(negedge clk);
    flush();
    repeat (FL + 10) @(negedge clk);
    check("no_frames", rx_q.size(), 0);
    check("post_rst_tx", tx, 1);

`ifdef UART_TX_PARITY_EN
    wr(3'h0, 32'h07);
    wr(3'h0, 32'h03);
    wait_rx(2, 2 * FL + 20, "par_count");
    if (rx_q.size() >= 2) begin
      check("par_b0", rx_q[0], 8'h07);
      check("par_p0", par_q[0], 1);
      check("par_b1", rx_q[1], 8'h03);
      check("par_p1", par_q[1], 0);
      check("par_gap", t_q[1] - t_q[0], FL + 1);
    end
    repeat (5) @(negedge clk);
    rd(3'h4, 32'h14, "par_status");
    flush();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
